simd_exec_unit: RTL
===================

Name: simd_exec_unit

Overview:
- Execute/writeback stage directly downstream of control_unit.
- Consumes decoded enables and register indices, reads a 32-entry packed-SIMD register file, and performs lane-wise add/sub/mul/bitrev.
- Writes results back to the register file through a 2-stage pipeline (EX, WB), with full operand forwarding.
- Provides a debug port so the bench and loader can seed and inspect registers.

Parameters:
- LANE_W, 8, bits per SIMD lane.
- NUM_LANES, 4, lanes per word. DATA_W = LANE_W*NUM_LANES = 32.
- NUM_REGS, 32, register count, addressed by 5-bit indices.
- CNT_W, 16, width of retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- rs1_rd_en  in  1  read rs1. When 0, operand A = 0.
- rs2_rd_en  in  1  read rs2. When 0, operand B = 0.
- rd_wr_en  in  1  write result to rd.
- add_en, sub_en, mul_en, bitrev_en  in  1 each  op select, one-hot.
- rs1, rs2, rd  in  5 each  register indices.
- dbg_addr  in  5  debug read/write index.
- dbg_wr_en  in  1  debug write strobe.
- dbg_wr_data  in  32  debug write data.
- dbg_rd_data  out  32  combinational regfile[dbg_addr]. Raw array value, no bypass.
- result  out  32  WB-stage result.
- result_rd  out  5  WB-stage destination.
- result_valid  out  1  WB stage holds a retired instruction.
- op_err  out  1  one-cycle pulse, aligned with WB: issued instruction had more than one op enable.
- retired_cnt  out  CNT_W  count of retired valid instructions.

Behaviour:
- Reset (rst=0, async):
  - All regfile entries = 0.
  - EX/WB valid = 0; result, result_rd, op_err, retired_cnt = 0.
- Issue:
  - An instruction is valid when exactly one op enable is high.
  - All op enables 0 = bubble: no write, no count, no error.
  - More than one op enable = treated as bubble, and op_err = 1 when that slot reaches WB.
- EX capture (posedge N):
  - Latches op, rd, rd_wr_en and operands A and B.
  - Operand source priority for index rsX:
    1. rsX==0 → 0.
    2. EX stage valid & wr & ex_rd==rsX → combinational ALU output of EX.
    3. WB stage valid & wr & result_rd==rsX → result.
    4. Otherwise regfile[rsX].
- WB capture (posedge N+1):
  - result, result_rd and result_valid are updated; latency issue→result_valid is 2 edges.
  - Back-to-back dependent instructions run without stalls.
- Regfile write (posedge N+2):
  - Write occurs if result_valid & stored wr_en & result_rd!=0.
  - retired_cnt increments on every posedge where result_valid=1, and wraps at 2^CNT_W-1 → 0.
- ALU, per lane i (bits i*8+7:i*8), no carries between lanes:
  - add: (A+B) mod 256.
  - sub: (A-B) mod 256.
  - mul: low 8 bits of A*B, unsigned.
  - bitrev: bit order reversed within each lane of A; B ignored.
- Register 0:
  - Always reads 0.
  - Pipeline writes and debug writes to r0 are dropped.
- Debug write:
  - Takes effect at posedge.
  - Same address as a pipeline writeback in the same cycle: pipeline wins.
  - Different addresses: both writes occur.
  - Debug writes are not forwarded; an instruction reading that register in the same cycle sees the old value.
- Reset mid-operation: in-flight EX/WB instructions are discarded and do not write.

Test Plan:
- Debug-write r1=0x01FF_7F80 and r2=0x0101_0180; ADD r3=r1+r2, wr_en=1 → 2 cycles later result=0x0200_8000, result_rd=3, result_valid=1; afterwards dbg_rd_data(r3)=0x0200_8000.
- SUB r4=r2-r1 → result=0x0002_82_00 (lanes 0x00,0x02,0x82,0x00 from MSB); MUL with r5=0x0203_1010, r6=0x0304_1111 → 0x060C_1010; BITREV r5 → 0x40C0_0808.
- Back-to-back dependency ADD r7=r1+r2, then ADD r8=r7+r7 on the next cycle → result for r8=0x0400_0000 with no stall. Repeat with one bubble between the instructions (WB forwarding) → same value.
- Write to r0 and rs1_rd_en=0 case: ADD rd=0 → r0 still reads 0. ADD r9 with rs1_rd_en=0, rs2=r2 → r9=0x0101_0180.
- add_en=1 and mul_en=1 together with rd=10 → op_err pulses once, 2 edges later; r10 unchanged; retired_cnt unchanged. Drive retired_cnt from preload 0xFFFF with one retire → 0x0000.
- Assert rst low while an ADD sits in EX → no regfile write; all outputs 0 immediately (async). Simultaneous debug write and pipeline write to r11 → pipeline value retained.

Source files
------------

// File: rtl/simd_exec_unit.sv
// rtl/simd_exec_unit.sv - packed-SIMD execute/writeback stage with register file and forwarding
//
// Two-stage (EX, WB) lane-wise add/sub/mul/bitrev unit fed by decoded enables.
// Ports:
//   clk, rst                   clock (rising edge), asynchronous active-low reset
//   rs1_rd_en, rs2_rd_en       operand read enables (operand is 0 when low)
//   rd_wr_en                   write the result back to rd
//   add_en/sub_en/mul_en/bitrev_en  one-hot op select; none = bubble, several = error bubble
//   rs1, rs2, rd               register indices
//   dbg_addr, dbg_wr_en, dbg_wr_data, dbg_rd_data  debug access to the raw register array
//   result, result_rd, result_valid  WB-stage contents
//   op_err                     pulse aligned with WB for a multi-enable issue slot
//   retired_cnt                count of retired valid instructions (wraps)
module simd_exec_unit #(
  parameter int LANE_W    = 8,
  parameter int NUM_LANES = 4,
  parameter int NUM_REGS  = 32,
  parameter int CNT_W     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          rs1_rd_en,
  input  logic                          rs2_rd_en,
  input  logic                          rd_wr_en,
  input  logic                          add_en,
  input  logic                          sub_en,
  input  logic                          mul_en,
  input  logic                          bitrev_en,
  input  logic [4:0]                    rs1,
  input  logic [4:0]                    rs2,
  input  logic [4:0]                    rd,
  input  logic [4:0]                    dbg_addr,
  input  logic                          dbg_wr_en,
  input  logic [LANE_W*NUM_LANES-1:0]   dbg_wr_data,
  output logic [LANE_W*NUM_LANES-1:0]   dbg_rd_data,
  output logic [LANE_W*NUM_LANES-1:0]   result,
  output logic [4:0]                    result_rd,
  output logic                          result_valid,
  output logic                          op_err,
  output logic [CNT_W-1:0]              retired_cnt
);

  localparam int DATA_W = LANE_W * NUM_LANES;

  typedef enum logic [1:0] {
    OP_ADD    = 2'd0,
    OP_SUB    = 2'd1,
    OP_MUL    = 2'd2,
    OP_BITREV = 2'd3
  } op_t;

  logic [DATA_W-1:0] regfile [NUM_REGS];

  logic [3:0]        op_en;
  logic              issue_valid;
  logic              issue_err;
  op_t               issue_op;

  logic              ex_valid;
  logic              ex_err;
  logic              ex_wr;
  logic [4:0]        ex_rd;
  op_t               ex_op;
  logic [DATA_W-1:0] ex_a;
  logic [DATA_W-1:0] ex_b;
  logic [DATA_W-1:0] alu_out;

  logic              wb_wr;
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;

  logic [LANE_W-1:0] la;
  logic [LANE_W-1:0] lb;
  logic [LANE_W-1:0] lr;

  assign op_en       = {bitrev_en, mul_en, sub_en, add_en};
  assign issue_valid = $onehot(op_en);
  assign issue_err   = (op_en != 4'd0) && !issue_valid;

  // Encoding only matters for valid (one-hot) slots.
  always_comb begin
    issue_op = OP_ADD;
    if (bitrev_en)    issue_op = OP_BITREV;
    else if (mul_en)  issue_op = OP_MUL;
    else if (sub_en)  issue_op = OP_SUB;
  end

  // Lane-wise ALU; each lane works only on its own slice, so no carry crosses a lane.
  always_comb begin
    alu_out = '0;
    la      = '0;
    lb      = '0;
    lr      = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      la = ex_a[i*LANE_W +: LANE_W];
      lb = ex_b[i*LANE_W +: LANE_W];
      case (ex_op)
        OP_ADD:    lr = la + lb;
        OP_SUB:    lr = la - lb;
        OP_MUL:    lr = la * lb;
        OP_BITREV: begin
          for (int j = 0; j < LANE_W; j++) lr[j] = la[LANE_W-1-j];
        end
        default:   lr = '0;
      endcase
      alu_out[i*LANE_W +: LANE_W] = lr;
    end
  end

  // Operand selection: r0 and disabled reads give 0; the younger EX result beats
  // the older WB result, which beats the register array.
  always_comb begin
    opnd_a = '0;
    if (rs1_rd_en && rs1 != 5'd0) begin
      if (ex_valid && ex_wr && ex_rd == rs1)                 opnd_a = alu_out;
      else if (result_valid && wb_wr && result_rd == rs1)    opnd_a = result;
      else                                                   opnd_a = regfile[rs1];
    end
  end

  always_comb begin
    opnd_b = '0;
    if (rs2_rd_en && rs2 != 5'd0) begin
      if (ex_valid && ex_wr && ex_rd == rs2)                 opnd_b = alu_out;
      else if (result_valid && wb_wr && result_rd == rs2)    opnd_b = result;
      else                                                   opnd_b = regfile[rs2];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ex_valid     <= 1'b0;
      ex_err       <= 1'b0;
      ex_wr        <= 1'b0;
      ex_rd        <= 5'd0;
      ex_op        <= OP_ADD;
      ex_a         <= '0;
      ex_b         <= '0;
      result_valid <= 1'b0;
      wb_wr        <= 1'b0;
      result_rd    <= 5'd0;
      result       <= '0;
      op_err       <= 1'b0;
      retired_cnt  <= '0;
    end else begin
      ex_valid     <= issue_valid;
      ex_err       <= issue_err;
      ex_wr        <= rd_wr_en;
      ex_rd        <= rd;
      ex_op        <= issue_op;
      ex_a         <= opnd_a;
      ex_b         <= opnd_b;
      result_valid <= ex_valid;
      wb_wr        <= ex_valid && ex_wr;
      result_rd    <= ex_valid ? ex_rd : 5'd0;
      result       <= ex_valid ? alu_out : '0;
      op_err       <= ex_err;
      if (result_valid) retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

  // The pipeline write is issued last so it overrides a same-address debug write.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regfile[i] <= '0;
    end else begin
      if (dbg_wr_en && dbg_addr != 5'd0) regfile[dbg_addr] <= dbg_wr_data;
      if (result_valid && wb_wr && result_rd != 5'd0) regfile[result_rd] <= result;
    end
  end

  assign dbg_rd_data = regfile[dbg_addr];

endmodule
